aes_cipher_engine: RTL and testbench
====================================

AES_CIPHER_ENGINE -- requirements
Module: aes_cipher_engine

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the number of cipher rounds (AES-128 only; no other value is supported).
REQ-002 The block SHALL have port clk_i, input, 1, meaning the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_ni, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port start_i, input, 1, meaning a request to encrypt block_i.
REQ-005 The block SHALL have port block_i, input, 128, meaning the plaintext; byte 0 is [127:120], FIPS-197 column-major state order.
REQ-006 The block SHALL have port ready_o, output, 1, meaning the engine is idle and will accept start_i.
REQ-007 The block SHALL have port key_idx_o, output, 4, meaning the index of the round key requested, 0..10.
REQ-008 The block SHALL have port round_key_i, input, 128, meaning the round key for key_idx_o, supplied by the key expansion stage.
REQ-009 The block SHALL have port round_key_valid_i, input, 1, meaning round_key_i is valid for the current key_idx_o.
REQ-010 The block SHALL have port block_o, output, 128, meaning the ciphertext.
REQ-011 The block SHALL have port valid_o, output, 1, meaning a one-cycle pulse marking a new block_o.

Function
REQ-012 The engine SHALL implement the FSM states IDLE and RUN; IDLE -> RUN on start_i while in IDLE; RUN -> IDLE on the step that consumes key 10.
REQ-013 In IDLE, ready_o SHALL be 1 and key_idx_o SHALL be 0; in RUN, ready_o SHALL be 0.
REQ-014 On the accepting edge, the engine SHALL latch block_i into the state register and clear the step counter to 0.
REQ-015 In RUN, the engine SHALL perform one step per edge where round_key_valid_i=1 and hold the state, counter and key_idx_o unchanged where it is 0, with no limit on stall length.
REQ-016 The step operations SHALL be as follows:
- step 0: AddRoundKey(key 0);
- steps 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(key n);
- step 10: SubBytes, ShiftRows, AddRoundKey(key 10), with no MixColumns.
REQ-017 key_idx_o SHALL equal the step counter in RUN.
REQ-018 MixColumns SHALL use GF(2^8) multiplication with polynomial 0x11B, and the S-box SHALL be the FIPS-197 forward table.
REQ-019 On the step-10 edge, the engine SHALL register the result into block_o and drive valid_o=1 for exactly the following cycle.
REQ-020 With round_key_valid_i held at 1, valid_o SHALL be high in the cycle after the 11th edge following start acceptance (latency 12 cycles from the start_i cycle).
REQ-021 start_i in RUN SHALL be ignored with no effect, including block_i not being latched.
REQ-022 start_i in the cycle valid_o is high SHALL be accepted, because the state is already IDLE, enabling back-to-back blocks every 12 cycles.
REQ-023 block_o SHALL hold its value until the next completion.
REQ-024 A round_key_valid_i pulse in IDLE SHALL have no effect.

Reset
REQ-025 Assertion of rst_ni low SHALL take effect immediately, independent of clk_i, and force the following:
- state=IDLE, counter=0, key_idx_o=0;
- block_o=0, valid_o=0, ready_o=1;
- internal state register=0.
REQ-026 Reset during RUN SHALL abandon the block, produce no valid_o, and accept the first start_i after deassertion normally.

Configuration
REQ-027 With macro AES_ENGINE_ABORT_EN defined, the block SHALL add port abort_i, input, 1; abort_i=1 in RUN SHALL return the engine to IDLE on the next edge with counter=0 and no valid_o, keeping block_o unchanged.
REQ-028 When abort_i and a step-10 edge coincide, abort SHALL win and no valid_o SHALL be produced.
REQ-029 Without AES_ENGINE_ABORT_EN, port abort_i SHALL NOT exist and behaviour SHALL be as REQ-012..REQ-024.

Verification
REQ-030 FIPS-197 App. B check: key 2b7e151628aed2a6abf7158809cf4f3c with bench-supplied round keys, round_key_valid_i=1, block 3243f6a8885a308d313198a2e0370734 -> block_o=3925841d02dc09fbdc118597196a0b32, valid_o one cycle, 12 cycles after start.
REQ-031 FIPS-197 App. C.1 check: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Stall check: the App. B vector with round_key_valid_i low for 3 cycles at key_idx_o=4 and 5 -> same ciphertext, latency 18, key_idx_o frozen while low.
REQ-033 Busy and back-to-back check:
- start_i with a different block at cycle 5 of RUN -> ignored, App. B result unchanged;
- start_i on the valid_o cycle -> the second block completes 12 cycles later.
REQ-034 Reset check: rst_ni low at key_idx_o=6 -> outputs at reset values immediately, no valid_o; the next App. C.1 run is correct.
REQ-035 Abort check (with AES_ENGINE_ABORT_EN): abort_i at key_idx_o=7 -> ready_o=1 next cycle, no valid_o, block_o keeps its prior value.

Source files
------------

// File: rtl/aes_cipher_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_cipher_engine
// Description : Iterative AES-128 encryption engine, one round step per
//               accepted round key. Optional abort port when the macro
//               AES_ENGINE_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_cipher_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [127:0] block_i,
`ifdef AES_ENGINE_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         ready_o,
    output logic [3:0]   key_idx_o,
    input  logic [127:0] round_key_i,
    input  logic         round_key_valid_i,
    output logic [127:0] block_o,
    output logic         valid_o
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;
    localparam logic [3:0] c_LAST = 4'(NUM_ROUNDS);

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows; state byte (row, col) sits at index row + 4*col
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = sbox(s[127 - 8*(row + 4*((c + row) % 4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    logic [0:0]   r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_data;
    logic [127:0] r_block;
    logic         r_valid;

    logic [127:0] w_sub_shift;
    logic [127:0] w_mixed;
    logic [127:0] w_next;
    logic         w_abort;

`ifdef AES_ENGINE_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign w_sub_shift = sub_shift(r_data);
    assign w_mixed     = mix_columns(w_sub_shift);

    // Step 0 is the initial key whitening; the last step skips MixColumns
    always_comb begin
        w_next = w_mixed ^ round_key_i;
        if (r_cnt == 4'd0) begin
            w_next = r_data ^ round_key_i;
        end else if (r_cnt == c_LAST) begin
            w_next = w_sub_shift ^ round_key_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_data  <= '0;
            r_block <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_state <= c_RUN;
                        r_cnt   <= 4'd0;
                        r_data  <= block_i;
                    end
                end
                c_RUN: begin
                    // Abort takes priority even over the final step
                    if (w_abort) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (round_key_valid_i) begin
                        r_data <= w_next;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_IDLE;
                            r_cnt   <= 4'd0;
                            r_block <= w_next;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ready_o   = (r_state == c_IDLE);
    assign key_idx_o = r_cnt;
    assign block_o   = r_block;
    assign valid_o   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_cipher_engine
// Description : Scoreboard bench for aes_cipher_engine using FIPS-197 vectors;
//               abort scenarios are built when AES_ENGINE_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_engine;

    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [127:0] block_i;
    logic         ready_o;
    logic [3:0]   key_idx_o;
    logic [127:0] round_key_i;
    logic         round_key_valid_i;
    logic [127:0] block_o;
    logic         valid_o;
`ifdef AES_ENGINE_ABORT_EN
    logic         abort_i;
`endif

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [127:0] rk_b [16];
    logic [127:0] rk_c [16];
    logic         key_sel;
    logic [127:0] last_ct;
    logic         found;

    aes_cipher_engine #(.NUM_ROUNDS(10)) u_dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .start_i           (start_i),
        .block_i           (block_i),
`ifdef AES_ENGINE_ABORT_EN
        .abort_i           (abort_i),
`endif
        .ready_o           (ready_o),
        .key_idx_o         (key_idx_o),
        .round_key_i       (round_key_i),
        .round_key_valid_i (round_key_valid_i),
        .block_o           (block_o),
        .valid_o           (valid_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Key expansion stage stand-in: serves the round key for the requested index
    always_comb round_key_i = key_sel ? rk_c[key_idx_o] : rk_b[key_idx_o];

    function automatic logic [7:0] sb_lookup(input logic [7:0] x);
        return c_SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_lookup(t[31:24]), sb_lookup(t[23:16]), sb_lookup(t[15:8]), sb_lookup(t[7:0])};
                t[31:24] = t[31:24] ^ rcon;
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 128'(valid_o), 128'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ciphertext", block_o, mon_e.ct);
                check("latency", 128'(cyc), 128'(mon_e.due));
                last_ct = mon_e.ct;
            end
        end
    end

    // Called at #1 after a rising edge; the next edge accepts the block
    task automatic start_block(input logic [127:0] pt, input logic [127:0] ct,
                               input logic sel, input int lat);
        key_sel = sel;
        block_i = pt;
        start_i = 1'b1;
        sb_q.push_back('{ct: ct, due: cyc + lat});
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk_i);
        check("drain", 128'(sb_q.size()), 128'd0);
        sb_q.delete();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_idx(input logic [3:0] idx);
        for (int i = 0; i < 40 && key_idx_o !== idx; i++) begin
            @(posedge clk_i); #1;
        end
        check("reach_idx", 128'(key_idx_o), 128'(idx));
    endtask

    task automatic stall_at(input logic [3:0] idx);
        round_key_valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            check("stall_idx", 128'(key_idx_o), 128'(idx));
        end
        round_key_valid_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            rk_b[r] = (r <= 10) ? round_key(c_KEY_B, r) : '0;
            rk_c[r] = (r <= 10) ? round_key(c_KEY_C, r) : '0;
        end
        rst_ni = 1'b0; start_i = 1'b0; block_i = '0; round_key_valid_i = 1'b1;
        key_sel = 1'b0; last_ct = '0; found = 1'b0;
`ifdef AES_ENGINE_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i); #1;
        check("rst_ready", 128'(ready_o), 128'd1);
        check("rst_key_idx", 128'(key_idx_o), 128'd0);
        check("rst_valid", 128'(valid_o), 128'd0);
        check("rst_block", block_o, 128'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // App. B vector, continuous keys
        start_block(c_PT_B, c_CT_B, 1'b0, 12);
        check("run_ready", 128'(ready_o), 128'd0);
        wait_done(30);
        check("idle_ready", 128'(ready_o), 128'd1);
        check("idle_key_idx", 128'(key_idx_o), 128'd0);

        // App. C.1 vector
        start_block(c_PT_C, c_CT_C, 1'b1, 12);
        wait_done(30);

        // Stalls of 3 cycles at key indices 4 and 5
        start_block(c_PT_B, c_CT_B, 1'b0, 18);
        wait_idx(4'd4);
        stall_at(4'd4);
        check("after_stall_idx", 128'(key_idx_o), 128'd5);
        stall_at(4'd5);
        wait_done(40);

        // Start ignored while busy, then back-to-back on the valid cycle
        start_block(c_PT_B, c_CT_B, 1'b0, 12);
        repeat (4) @(posedge clk_i); #1;
        block_i = c_PT_C;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("busy_ready", 128'(ready_o), 128'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk_i); #1;
            found = valid_o;
        end
        check("b2b_first_valid", 128'(found), 128'd1);
        start_block(c_PT_C, c_CT_C, 1'b1, 12);
        wait_done(30);

        // Asynchronous reset mid-block
        start_block(c_PT_B, c_CT_B, 1'b0, 12);
        wait_idx(4'd6);
        #2 rst_ni = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_ready", 128'(ready_o), 128'd1);
        check("midrst_key_idx", 128'(key_idx_o), 128'd0);
        check("midrst_valid", 128'(valid_o), 128'd0);
        check("midrst_block", block_o, 128'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        start_block(c_PT_C, c_CT_C, 1'b1, 12);
        wait_done(30);

`ifdef AES_ENGINE_ABORT_EN
        // Abort mid-block and abort coinciding with the final step
        start_block(c_PT_B, c_CT_B, 1'b0, 12);
        wait_idx(4'd7);
        abort_i = 1'b1;
        sb_q.delete();
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check("abort_ready", 128'(ready_o), 128'd1);
        check("abort_key_idx", 128'(key_idx_o), 128'd0);
        check("abort_block", block_o, last_ct);
        repeat (15) @(posedge clk_i); #1;
        start_block(c_PT_B, c_CT_B, 1'b0, 12);
        wait_idx(4'd10);
        abort_i = 1'b1;
        sb_q.delete();
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check("abort10_ready", 128'(ready_o), 128'd1);
        check("abort10_valid", 128'(valid_o), 128'd0);
        check("abort10_block", block_o, last_ct);
        repeat (5) @(posedge clk_i); #1;
        start_block(c_PT_B, c_CT_B, 1'b0, 12);
        wait_done(30);
`endif

        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
